// File: rtl/rs_issue_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rs_issue_queue_pkg
// Brief    : Shared types for the reservation station (dispatch op, RS entry).
// Revision : 1.0
// ============================================================================
package rs_issue_queue_pkg;

    localparam int PKG_PREG_W = 7;
    localparam int PKG_NUM_FU = 2;
    localparam int FU_W       = (PKG_NUM_FU > 1) ? $clog2(PKG_NUM_FU) : 1;
    localparam int OP_W       = 8;

    typedef struct packed {
        logic [OP_W-1:0]       opcode;
        logic [PKG_PREG_W-1:0] prd;
        logic [PKG_PREG_W-1:0] pr1;
        logic                  pr1_ready;
        logic [PKG_PREG_W-1:0] pr2;
        logic                  pr2_ready;
    } dispatch_pipeline_data;

    typedef struct packed {
        logic [FU_W-1:0]       fu;
        logic [OP_W-1:0]       opcode;
        logic [PKG_PREG_W-1:0] prd;
        logic [PKG_PREG_W-1:0] pr1;
        logic                  pr1_ready;
        logic [PKG_PREG_W-1:0] pr2;
        logic                  pr2_ready;
    } rs_data;

endpackage
`default_nettype wire

// File: rtl/rs_issue_queue_age_select.sv
`default_nettype none
// ============================================================================
// Module   : rs_age_select
// Brief    : Picks the candidate older than every other candidate (one-hot).
// Revision : 1.0
// ============================================================================
module rs_age_select
    import rs_issue_queue_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic [DEPTH-1:0]       cand,
    input  logic [DEPTH*DEPTH-1:0] old,
    output logic [DEPTH-1:0]       grant
);

    // old[i*DEPTH+j] set means entry i is older than entry j
    always_comb begin
        grant = '0;
        for (int i = 0; i < DEPTH; i++) begin
            grant[i] = cand[i];
            for (int j = 0; j < DEPTH; j++) begin
                if (j != i && cand[j] && !old[i*DEPTH + j]) begin
                    grant[i] = 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rs_issue_queue.sv
`default_nettype none
// ============================================================================
// Module   : rs_issue_queue
// Brief    : Age-ordered reservation station with wakeup bypass and RR FU binding.
// Revision : 1.0
// ============================================================================
module rs_issue_queue
    import rs_issue_queue_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int DISP_W   = 2,
    parameter int NUM_FU   = PKG_NUM_FU,
    parameter int NUM_WAKE = 2,
    parameter int PREG_W   = PKG_PREG_W
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 flush,
    input  logic [DISP_W-1:0]                    valid_in,
    input  dispatch_pipeline_data [DISP_W-1:0]   instr_in,
    output logic [DISP_W-1:0]                    ready_in,
    output logic [DISP_W-1:0]                    busy_valid,
    output logic [DISP_W-1:0][PREG_W-1:0]        busy_preg,
    input  logic [NUM_WAKE-1:0]                  wake_valid,
    input  logic [NUM_WAKE-1:0][PREG_W-1:0]      wake_preg,
    input  logic [NUM_FU-1:0]                    fu_rdy,
    output logic [NUM_FU-1:0]                    issue_valid,
    output rs_data [NUM_FU-1:0]                  issue_data,
    output logic [$clog2(DEPTH):0]               free_count
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int IDX_W = $clog2(DEPTH);

    logic [DEPTH-1:0]              r_valid;
    rs_data [DEPTH-1:0]            r_entry;
    logic [DEPTH-1:0][DEPTH-1:0]   r_old;
    logic [FU_W-1:0]               r_rr_ptr;
    logic [CNT_W-1:0]              r_free_count;
    logic [DISP_W-1:0]             r_busy_valid;
    logic [DISP_W-1:0][PREG_W-1:0] r_busy_preg;

    logic [DISP_W-1:0]             w_accept;
    logic [DISP_W-1:0][IDX_W-1:0]  w_slot;
    logic [DISP_W-1:0][FU_W-1:0]   w_lane_fu;
    logic [CNT_W-1:0]              w_acc_cnt;
    logic [NUM_FU-1:0][DEPTH-1:0]  w_cand;
    logic [NUM_FU-1:0][DEPTH-1:0]  w_grant;
    logic [DEPTH-1:0]              w_issue_free;
    logic [DEPTH-1:0]              w_valid_nxt;
    rs_data [DEPTH-1:0]            w_entry_nxt;
    logic [DEPTH-1:0][DEPTH-1:0]   w_old_nxt;

    function automatic logic tag_hit(input logic [PREG_W-1:0] tag,
                                     input logic [NUM_WAKE-1:0] wv,
                                     input logic [NUM_WAKE-1:0][PREG_W-1:0] wp);
        logic hit;
        hit = 1'b0;
        for (int w = 0; w < NUM_WAKE; w++) begin
            if (wv[w] && wp[w] == tag) hit = 1'b1;
        end
        return hit;
    endfunction

    // Admission looks only at registered occupancy, so slots freed this cycle wait a cycle
    for (genvar k = 0; k < DISP_W; k++) begin : g_ready
        assign ready_in[k] = (r_free_count > CNT_W'(k));
    end

    always_comb begin
        logic [DEPTH-1:0] free_mask;
        logic             found;
        int unsigned      base;
        int unsigned      n_acc;
        free_mask = ~r_valid;
        found     = 1'b0;
        base      = 32'(r_rr_ptr);
        n_acc     = 0;
        w_accept  = '0;
        w_slot    = '0;
        w_lane_fu = '0;
        for (int k = 0; k < DISP_W; k++) begin
            if (valid_in[k] && ready_in[k] && !flush) begin
                w_accept[k]  = 1'b1;
                w_lane_fu[k] = FU_W'((base + n_acc) % 32'(NUM_FU));
                n_acc        = n_acc + 1;
                found        = 1'b0;
                for (int i = 0; i < DEPTH; i++) begin
                    if (!found && free_mask[i]) begin
                        found        = 1'b1;
                        w_slot[k]    = IDX_W'(i);
                        free_mask[i] = 1'b0;
                    end
                end
            end
        end
        w_acc_cnt = CNT_W'(n_acc);
    end

    always_comb begin
        w_cand = '0;
        for (int f = 0; f < NUM_FU; f++) begin
            for (int i = 0; i < DEPTH; i++) begin
                w_cand[f][i] = r_valid[i] && (r_entry[i].fu == FU_W'(f))
                               && r_entry[i].pr1_ready && r_entry[i].pr2_ready;
            end
        end
    end

    for (genvar f = 0; f < NUM_FU; f++) begin : g_sel
        rs_age_select #(.DEPTH(DEPTH)) u_age_select (
            .cand  (w_cand[f]),
            .old   (r_old),
            .grant (w_grant[f])
        );
        assign issue_valid[f] = (|w_grant[f]) && fu_rdy[f] && !flush;
    end

    always_comb begin
        w_issue_free = '0;
        for (int f = 0; f < NUM_FU; f++) begin
            issue_data[f] = '0;
            for (int i = 0; i < DEPTH; i++) begin
                if (w_grant[f][i] && issue_valid[f]) begin
                    issue_data[f]   = r_entry[i];
                    w_issue_free[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        logic [DEPTH-1:0] written;
        written     = '0;
        w_valid_nxt = r_valid & ~w_issue_free;
        w_entry_nxt = r_entry;
        w_old_nxt   = r_old;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i] && r_entry[i].pr1 != '0 && tag_hit(r_entry[i].pr1, wake_valid, wake_preg))
                w_entry_nxt[i].pr1_ready = 1'b1;
            if (r_valid[i] && r_entry[i].pr2 != '0 && tag_hit(r_entry[i].pr2, wake_valid, wake_preg))
                w_entry_nxt[i].pr2_ready = 1'b1;
        end
        // New entries are younger than everything resident and every earlier lane
        for (int k = 0; k < DISP_W; k++) begin
            if (w_accept[k]) begin
                w_entry_nxt[w_slot[k]].fu        = w_lane_fu[k];
                w_entry_nxt[w_slot[k]].opcode    = instr_in[k].opcode;
                w_entry_nxt[w_slot[k]].prd       = instr_in[k].prd;
                w_entry_nxt[w_slot[k]].pr1       = instr_in[k].pr1;
                w_entry_nxt[w_slot[k]].pr2       = instr_in[k].pr2;
                w_entry_nxt[w_slot[k]].pr1_ready = instr_in[k].pr1_ready || (instr_in[k].pr1 == '0)
                                                   || tag_hit(instr_in[k].pr1, wake_valid, wake_preg);
                w_entry_nxt[w_slot[k]].pr2_ready = instr_in[k].pr2_ready || (instr_in[k].pr2 == '0)
                                                   || tag_hit(instr_in[k].pr2, wake_valid, wake_preg);
                w_valid_nxt[w_slot[k]] = 1'b1;
                for (int i = 0; i < DEPTH; i++) begin
                    w_old_nxt[w_slot[k]][i] = 1'b0;
                    w_old_nxt[i][w_slot[k]] = r_valid[i] | written[i];
                end
                written[w_slot[k]] = 1'b1;
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (w_issue_free[i]) begin
                w_old_nxt[i] = '0;
                for (int j = 0; j < DEPTH; j++) w_old_nxt[j][i] = 1'b0;
            end
        end
        if (flush) begin
            w_valid_nxt = '0;
            w_old_nxt   = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid      <= '0;
            r_entry      <= '0;
            r_old        <= '0;
            r_rr_ptr     <= '0;
            r_free_count <= CNT_W'(DEPTH);
            r_busy_valid <= '0;
            r_busy_preg  <= '0;
        end else begin
            r_valid      <= w_valid_nxt;
            r_entry      <= w_entry_nxt;
            r_old        <= w_old_nxt;
            r_rr_ptr     <= FU_W'((32'(r_rr_ptr) + 32'(w_acc_cnt)) % 32'(NUM_FU));
            r_free_count <= CNT_W'(DEPTH) - CNT_W'($countones(w_valid_nxt));
            r_busy_valid <= w_accept;
            for (int k = 0; k < DISP_W; k++) begin
                r_busy_preg[k] <= w_accept[k] ? instr_in[k].prd : '0;
            end
        end
    end

    assign free_count = r_free_count;
    assign busy_valid = r_busy_valid;
    assign busy_preg  = r_busy_preg;

endmodule
`default_nettype wire

// File: tb/tb_rs_issue_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_rs_issue_queue
// Brief    : Directed stimulus with per-FU issue scoreboard and busy-tag scoreboard.
// Revision : 1.0
// ============================================================================
module tb_rs_issue_queue;
    import rs_issue_queue_pkg::*;

    logic                            clk;
    logic                            reset;
    logic                            flush;
    logic [1:0]                      valid_in;
    dispatch_pipeline_data [1:0]     instr_in;
    logic [1:0]                      ready_in;
    logic [1:0]                      busy_valid;
    logic [1:0][6:0]                 busy_preg;
    logic [1:0]                      wake_valid;
    logic [1:0][6:0]                 wake_preg;
    logic [1:0]                      fu_rdy;
    logic [1:0]                      issue_valid;
    rs_data [1:0]                    issue_data;
    logic [3:0]                      free_count;

    int     total = 0;
    int     bad   = 0;
    int     rr    = 0;
    rs_data exp_q [2][$];
    logic [7:0] busy_q [$];

    rs_issue_queue #(.DEPTH(8), .DISP_W(2), .NUM_FU(2), .NUM_WAKE(2), .PREG_W(7)) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .valid_in    (valid_in),
        .instr_in    (instr_in),
        .ready_in    (ready_in),
        .busy_valid  (busy_valid),
        .busy_preg   (busy_preg),
        .wake_valid  (wake_valid),
        .wake_preg   (wake_preg),
        .fu_rdy      (fu_rdy),
        .issue_valid (issue_valid),
        .issue_data  (issue_data),
        .free_count  (free_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic dispatch_pipeline_data mkop(input logic [7:0] id, input logic [6:0] prd,
                                                   input logic [6:0] pr1, input logic r1,
                                                   input logic [6:0] pr2, input logic r2);
        dispatch_pipeline_data d;
        d.opcode = id; d.prd = prd; d.pr1 = pr1; d.pr1_ready = r1; d.pr2 = pr2; d.pr2_ready = r2;
        return d;
    endfunction

    // acc: ops expected accepted; iss: expect them to issue later; bsy: expect busy report
    task automatic disp(input logic [1:0] v, input dispatch_pipeline_data a,
                        input dispatch_pipeline_data b, input bit acc, input bit iss, input bit bsy);
        dispatch_pipeline_data lanes [2];
        lanes[0] = a;
        lanes[1] = b;
        valid_in = v;
        instr_in[0] = a;
        instr_in[1] = b;
        if (acc) begin
            for (int k = 0; k < 2; k++) begin
                if (v[k]) begin
                    rs_data e;
                    e.fu = FU_W'(rr); e.opcode = lanes[k].opcode; e.prd = lanes[k].prd;
                    e.pr1 = lanes[k].pr1; e.pr1_ready = 1'b1; e.pr2 = lanes[k].pr2; e.pr2_ready = 1'b1;
                    if (iss) exp_q[rr].push_back(e);
                    if (bsy) busy_q.push_back({k == 1, lanes[k].prd});
                    rr = (rr + 1) % 2;
                end
            end
        end
        @(posedge clk); #1;
        valid_in = '0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Monitor: every presented issue or busy report must match the head of its queue
    always @(negedge clk) begin
        for (int f = 0; f < 2; f++) begin
            if (issue_valid[f]) begin
                total++;
                if (exp_q[f].size() == 0) begin
                    bad++;
                    $display("FAIL issue_fu%0d unexpected actual=%h required=none", f, issue_data[f]);
                end else begin
                    rs_data e;
                    e = exp_q[f].pop_front();
                    if (issue_data[f] !== e) begin
                        bad++;
                        $display("FAIL issue_fu%0d actual=%h required=%h", f, issue_data[f], e);
                    end
                end
            end
        end
        for (int k = 0; k < 2; k++) begin
            if (busy_valid[k]) begin
                total++;
                if (busy_q.size() == 0) begin
                    bad++;
                    $display("FAIL busy_lane%0d unexpected actual=%h required=none", k, busy_preg[k]);
                end else begin
                    logic [7:0] e;
                    e = busy_q.pop_front();
                    if ({k == 1, busy_preg[k]} !== e) begin
                        bad++;
                        $display("FAIL busy_lane%0d actual=%h required=%h", k, {k == 1, busy_preg[k]}, e);
                    end
                end
            end
        end
    end

    initial begin
        reset = 1'b0; flush = 1'b0; valid_in = '0; instr_in = '0;
        wake_valid = '0; wake_preg = '0; fu_rdy = 2'b11;
        tick(2);
        chk("rst_free_count", 32'(free_count), 32'd8);
        chk("rst_issue_valid", 32'(issue_valid), 32'd0);
        chk("rst_busy_valid", 32'(busy_valid), 32'd0);
        chk("rst_ready_in", 32'(ready_in), 32'd3);
        reset = 1'b1;
        tick(1);

        // Two ready ops bind to FU0 then FU1 and issue the following cycle
        disp(2'b11, mkop(8'h01, 7'd10, 7'd3, 1'b1, 7'd4, 1'b1),
                    mkop(8'h02, 7'd11, 7'd3, 1'b1, 7'd0, 1'b0), 1, 1, 1);
        chk("t2_issue_valid", 32'(issue_valid), 32'd3);
        chk("t2_busy_valid", 32'(busy_valid), 32'd3);
        chk("t2_free_count", 32'(free_count), 32'd6);
        tick(1);
        chk("t2_drained", 32'(free_count), 32'd8);

        // Fill all eight entries waiting on tag 5
        for (int p = 0; p < 4; p++) begin
            disp(2'b11, mkop(8'(8'h10 + 2*p), 7'(20 + 2*p), 7'd5, 1'b0, 7'd0, 1'b0),
                        mkop(8'(8'h11 + 2*p), 7'(21 + 2*p), 7'd5, 1'b0, 7'd0, 1'b0), 1, 1, 1);
        end
        chk("t3_full_count", 32'(free_count), 32'd0);
        chk("t3_full_ready", 32'(ready_in), 32'd0);
        chk("t3_none_ready", 32'(issue_valid), 32'd0);
        wake_valid = 2'b01; wake_preg[0] = 7'd5;
        disp(2'b11, mkop(8'h40, 7'd40, 7'd0, 1'b1, 7'd0, 1'b1),
                    mkop(8'h41, 7'd41, 7'd0, 1'b1, 7'd0, 1'b1), 0, 0, 0);
        wake_valid = 2'b00;
        chk("t3_woken_issue", 32'(issue_valid), 32'd3);
        chk("t3_full_no_busy", 32'(busy_valid), 32'd0);
        tick(1);
        chk("t3_after1_count", 32'(free_count), 32'd2);
        chk("t3_after1_ready", 32'(ready_in), 32'd3);
        tick(3);
        chk("t3_drained", 32'(free_count), 32'd8);
        chk("t3_idle", 32'(issue_valid), 32'd0);

        // Wakeup in the dispatch cycle makes the op ready at write
        wake_valid = 2'b10; wake_preg[1] = 7'd9;
        disp(2'b01, mkop(8'h30, 7'd31, 7'd9, 1'b0, 7'd0, 1'b0), '0, 1, 1, 1);
        wake_valid = 2'b00;
        chk("t4_bypass_issue", 32'(issue_valid), 32'd1);
        tick(1);
        chk("t4_drained", 32'(free_count), 32'd8);

        // FU0 stalled: its three ops wait, FU1 ops flow
        fu_rdy = 2'b10;
        for (int p = 0; p < 3; p++) begin
            disp(2'b11, mkop(8'(8'h50 + p), 7'(50 + p), 7'd0, 1'b0, 7'd0, 1'b0),
                        mkop(8'(8'h60 + p), 7'(60 + p), 7'd0, 1'b0, 7'd0, 1'b0), 1, 1, 1);
            chk("t5_fu0_blocked", 32'(issue_valid[0]), 32'd0);
        end
        tick(1);
        chk("t5_fu0_blocked", 32'(issue_valid[0]), 32'd0);
        tick(1);
        chk("t5_all_blocked", 32'(issue_valid), 32'd0);
        fu_rdy = 2'b11; #1;
        chk("t5_release", 32'(issue_valid), 32'd1);
        tick(3);
        chk("t5_drained", 32'(free_count), 32'd8);

        // Flush with six resident ops and two lanes offered
        fu_rdy = 2'b00;
        for (int p = 0; p < 3; p++) begin
            disp(2'b11, mkop(8'(8'h70 + 2*p), 7'(70 + 2*p), 7'd0, 1'b1, 7'd0, 1'b1),
                        mkop(8'(8'h71 + 2*p), 7'(71 + 2*p), 7'd0, 1'b1, 7'd0, 1'b1), 1, 0, 1);
        end
        chk("t6_six_resident", 32'(free_count), 32'd2);
        flush = 1'b1; fu_rdy = 2'b11; valid_in = 2'b11;
        instr_in[0] = mkop(8'h7a, 7'd90, 7'd0, 1'b1, 7'd0, 1'b1);
        instr_in[1] = mkop(8'h7b, 7'd91, 7'd0, 1'b1, 7'd0, 1'b1);
        #1;
        chk("t6_flush_no_issue", 32'(issue_valid), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0; valid_in = '0;
        chk("t6_free_count", 32'(free_count), 32'd8);
        chk("t6_no_busy", 32'(busy_valid), 32'd0);
        chk("t6_no_issue", 32'(issue_valid), 32'd0);
        // rr pointer survives the flush
        disp(2'b11, mkop(8'h80, 7'd80, 7'd0, 1'b1, 7'd0, 1'b1),
                    mkop(8'h81, 7'd81, 7'd0, 1'b1, 7'd0, 1'b1), 1, 1, 1);
        tick(1);

        // Reset in the middle of traffic drops everything
        fu_rdy = 2'b00;
        disp(2'b11, mkop(8'h90, 7'd92, 7'd0, 1'b1, 7'd0, 1'b1),
                    mkop(8'h91, 7'd93, 7'd0, 1'b1, 7'd0, 1'b1), 1, 0, 0);
        reset = 1'b0; #1;
        chk("t1_free_count", 32'(free_count), 32'd8);
        chk("t1_issue_valid", 32'(issue_valid), 32'd0);
        chk("t1_busy_valid", 32'(busy_valid), 32'd0);
        fu_rdy = 2'b11; rr = 0;
        tick(1);
        reset = 1'b1;
        tick(2);
        disp(2'b11, mkop(8'hA0, 7'd100, 7'd0, 1'b1, 7'd0, 1'b1),
                    mkop(8'hA1, 7'd101, 7'd0, 1'b1, 7'd0, 1'b1), 1, 1, 1);
        chk("t1_post_issue", 32'(issue_valid), 32'd3);
        tick(2);

        chk("q_fu0_empty", 32'(exp_q[0].size()), 32'd0);
        chk("q_fu1_empty", 32'(exp_q[1].size()), 32'd0);
        chk("q_busy_empty", 32'(busy_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
